instruction_fetch_unit: RTL

- Fetch stage directly upstream of the main decoder/control unit in the single-issue MIPS datapath.
- Owns the PC and issues word requests to instruction memory with a req/ready handshake.
- Latches the returned instruction and presents Opcode [31:26] and Funct [5:0] to the control unit.
- Computes the next PC from the Jump/Branch decisions fed back by the control unit and the ALU Zero flag.

---
 rtl/instruction_fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over a req/ready handshake and presents the
// latched instruction to the control unit. Define FETCH_TIMEOUT_EN for the fetch watchdog.
module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StIssue,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [4:0] TimeoutLast = 5'(TIMEOUT_CYCLES - 1);

    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Jump beats a taken branch; the branch offset is in words.
    always_comb begin
        if (Jump) begin
            next_pc = {pc_plus4_q[31:28], JumpTarget, 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4_q + (BranchOffset << 2);
        end else begin
            next_pc = pc_plus4_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = req_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StBoot: begin
                req_d   = 1'b1;
                state_d = StReq;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StReq: begin
                if (IMemReady) begin
                    instr_d = IMemData;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = StIssue;
`ifdef FETCH_TIMEOUT_EN
                end else if (wait_cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
`endif
                end
            end
            StIssue: begin
                if (!Stall) begin
                    pc_d       = next_pc;
                    pc_plus4_d = next_pc + 32'd4;
                    valid_d    = 1'b0;
                    req_d      = 1'b1;
                    state_d    = StReq;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            StErr: begin
                // Terminal until reset.
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= PC_RESET;
            pc_plus4_q <= PC_RESET + 32'd4;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign FetchErr = err_q;
`else
    assign FetchErr = 1'b0;
`endif

    assign IMemReq    = req_q;
    assign IMemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_plus4_q;
    assign Instr      = instr_q;
    assign Opcode     = instr_q[31:26];
    assign Funct      = instr_q[5:0];
    assign InstrValid = valid_q;

endmodule
